// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding
// and the stage-register enable/flush bundle used by the hazard unit and stage registers.
package pipe_pkg;

    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_HALT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // A request acked in the same cycle is a single-cycle access, not a freeze.
    function automatic logic mem_freeze(input logic req, input logic ack);
        return req & ~ack;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count register with saturation at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: arbitrates memory freeze, redirect and load-use
// stalls into stage-register enables/flushes, with a memory-wait watchdog and perf counters.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [WAIT_W-1:0] L_TIMEOUT = WAIT_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_next_wait;
    logic                r_halted;
    ctrl_t               w_ctrl;
    logic                w_flush_inc;
    logic                w_stall_inc;

    // State, wait counter and sticky halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 16'd0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            r_halted   <= (w_next_state == ST_HALT);
        end
    end

    // Next-state and control-bundle decode; freeze outranks redirect outranks load-use
    always_comb begin
        w_ctrl       = CTRL_RUN;
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        w_flush_inc  = 1'b0;
        if (rst) begin
            w_ctrl = CTRL_RESET;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_freeze(dmem_req, dmem_ack)) begin
                        w_ctrl       = CTRL_FREEZE;
                        w_next_state = ST_MEM_WAIT;
                        w_next_wait  = 16'd1;
                    end else if (redirect) begin
                        w_ctrl      = CTRL_REDIRECT;
                        w_flush_inc = 1'b1;
                    end else if (stall_req) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end else begin
                        w_ctrl = CTRL_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    w_ctrl = CTRL_FREEZE;
                    if (dmem_ack) begin
                        w_next_state = ST_RUN;
                    end else if (r_wait_cnt == L_TIMEOUT) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_next_wait = r_wait_cnt + 16'd1;
                    end
                end
                ST_HALT: begin
                    w_ctrl = CTRL_HALT;
                end
                default: begin
                    w_ctrl       = CTRL_HALT;
                    w_next_state = ST_HALT;
                end
            endcase
        end
    end

    assign w_stall_inc = (r_state != ST_HALT) && !w_ctrl.pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_events)
    );

    assign pc_en        = w_ctrl.pc_en;
    assign if_id_en     = w_ctrl.if_id_en;
    assign id_ex_en     = w_ctrl.id_ex_en;
    assign ex_mem_en    = w_ctrl.ex_mem_en;
    assign mem_wb_en    = w_ctrl.mem_wb_en;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign mem_wb_flush = w_ctrl.mem_wb_flush;
    assign halted       = r_halted;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_stall_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;

    // Expected bundles: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes}
    localparam logic [7:0] E_RUN  = 8'b11111_000;
    localparam logic [7:0] E_RED  = 8'b11111_110;
    localparam logic [7:0] E_LU   = 8'b00111_010;
    localparam logic [7:0] E_FRZ  = 8'b00001_001;
    localparam logic [7:0] E_HALT = 8'b00000_000;
    localparam logic [7:0] E_RST  = 8'b00000_111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_req = 1'b0;
    logic redirect = 1'b0;
    logic dmem_req = 1'b0;
    logic dmem_ack = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, halted;
    logic [TB_CNT_W-1:0] stall_cycles, flush_events;
    logic [7:0] ctrl_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ctrl_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush};

    pipe_stall_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .redirect     (redirect),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall_req = 1'b0; redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RST) begin $display("FAIL reset_ctrl got %b want %b", ctrl_obs, E_RST); n_fail++; end
        n_tests++;
        if (halted !== 1'b0 || stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
            $display("FAIL reset_state halted=%b stall=%0d flush=%0d want 0/0/0", halted, stall_cycles, flush_events); n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RUN) begin $display("FAIL reset_run_idle got %b want %b", ctrl_obs, E_RUN); n_fail++; end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        stall_req = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_LU) begin $display("FAIL load_use_ctrl got %b want %b", ctrl_obs, E_LU); n_fail++; end
        @(posedge clk); #1;
        n_tests++;
        if (stall_cycles !== 4'd1 || flush_events !== 4'd0) begin
            $display("FAIL load_use_cnt stall=%0d flush=%0d want 1/0", stall_cycles, flush_events); n_fail++;
        end
        @(negedge clk);
        stall_req = 1'b0;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RUN) begin $display("FAIL load_use_release got %b want %b", ctrl_obs, E_RUN); n_fail++; end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        @(negedge clk);
        redirect = 1'b1; stall_req = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RED) begin $display("FAIL redirect_ctrl got %b want %b", ctrl_obs, E_RED); n_fail++; end
        @(posedge clk); #1;
        n_tests++;
        if (flush_events !== 4'd1 || stall_cycles !== 4'd0) begin
            $display("FAIL redirect_cnt flush=%0d stall=%0d want 1/0", flush_events, stall_cycles); n_fail++;
        end
        @(negedge clk);
        redirect = 1'b0; stall_req = 1'b0;
        // Freeze outranks a simultaneous redirect
        dmem_req = 1'b1; dmem_ack = 1'b0; redirect = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_FRZ) begin $display("FAIL freeze_over_redirect got %b want %b", ctrl_obs, E_FRZ); n_fail++; end
        @(negedge clk);
        dmem_ack = 1'b1; redirect = 1'b0;
        @(negedge clk);
        dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        n_tests++;
        if (flush_events !== 4'd1) begin $display("FAIL freeze_no_flush_cnt got %0d want 1", flush_events); n_fail++; end
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge clk);
        dmem_req = 1'b1; dmem_ack = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RUN) begin $display("FAIL single_cycle_access got %b want %b", ctrl_obs, E_RUN); n_fail++; end
        dmem_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) dmem_ack = 1'b1;
            #1;
            n_tests++;
            if (ctrl_obs !== E_FRZ) begin $display("FAIL mem_wait_ctrl cycle %0d got %b want %b", k, ctrl_obs, E_FRZ); n_fail++; end
            @(posedge clk); #1;
            n_tests++;
            if (stall_cycles !== 4'(k) || halted !== 1'b0) begin
                $display("FAIL mem_wait_cnt cycle %0d stall=%0d halted=%b want %0d/0", k, stall_cycles, halted, k); n_fail++;
            end
            @(negedge clk);
        end
        dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RUN) begin $display("FAIL mem_wait_resume got %b want %b", ctrl_obs, E_RUN); n_fail++; end
        @(posedge clk); #1;
        n_tests++;
        if (stall_cycles !== 4'd4) begin $display("FAIL mem_wait_total got %0d want 4", stall_cycles); n_fail++; end
    endtask

    task automatic test_watchdog();
        do_reset();
        @(negedge clk);
        dmem_req = 1'b1; dmem_ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_tests++;
            if (ctrl_obs !== E_FRZ) begin $display("FAIL watchdog_ctrl cycle %0d got %b want %b", k, ctrl_obs, E_FRZ); n_fail++; end
            @(posedge clk); #1;
            n_tests++;
            if (halted !== (k == 5) || stall_cycles !== 4'(k)) begin
                $display("FAIL watchdog_trip cycle %0d halted=%b stall=%0d want %b/%0d", k, halted, stall_cycles, (k == 5), k); n_fail++;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b1; redirect = 1'b1; stall_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (ctrl_obs !== E_HALT || halted !== 1'b1) begin
                $display("FAIL halt_hold ctrl=%b halted=%b want %b/1", ctrl_obs, halted, E_HALT); n_fail++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (stall_cycles !== 4'd5 || flush_events !== 4'd0) begin
            $display("FAIL halt_counters stall=%0d flush=%0d want 5/0", stall_cycles, flush_events); n_fail++;
        end
        dmem_req = 1'b0; dmem_ack = 1'b0; redirect = 1'b0; stall_req = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        dmem_req = 1'b1; dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RST || halted !== 1'b0 || stall_cycles !== 4'd0) begin
            $display("FAIL async_reset ctrl=%b halted=%b stall=%0d want %b/0/0", ctrl_obs, halted, stall_cycles, E_RST); n_fail++;
        end
        @(negedge clk);
        rst = 1'b0; dmem_req = 1'b0;
        #1;
        n_tests++;
        if (ctrl_obs !== E_RUN) begin $display("FAIL async_reset_run got %b want %b", ctrl_obs, E_RUN); n_fail++; end
        @(posedge clk); #1;
        n_tests++;
        if (stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
            $display("FAIL async_reset_cnt stall=%0d flush=%0d want 0/0", stall_cycles, flush_events); n_fail++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        stall_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 14 || k == 15 || k == 20) begin
                n_tests++;
                if (stall_cycles !== 4'(k > 15 ? 15 : k)) begin
                    $display("FAIL stall_saturate cycle %0d got %0d want %0d", k, stall_cycles, (k > 15 ? 15 : k)); n_fail++;
                end
            end
        end
        @(negedge clk);
        stall_req = 1'b0; redirect = 1'b1;
        for (int k = 1; k <= 17; k++) @(posedge clk);
        #1;
        n_tests++;
        if (flush_events !== 4'd15) begin $display("FAIL flush_saturate got %0d want 15", flush_events); n_fail++; end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_mem_wait();
        test_watchdog();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
